safe_access_ctrl: RTL and testbench
===================================

# safe_access_ctrl

Access-control sequencer for the 4-digit programmable safe. It sits between the button pulse conditioner and the digit-switch/display path. It owns the stored password, the open/locked/programming/lockout state, the failed-attempt counter and the lockout timer. All status outputs (open, wrong, mode, factory) are registered here and drive the board LEDs directly.

## Interface
Parameters:
- DIGIT_W, 3: bits per password digit; code is 4*DIGIT_W bits.
- MAX_TRIES, 3: wrong attempts before lockout; legal range 1..3.
- LOCKOUT_CYCLES, 100_000_000: lockout duration in clk cycles; must be at least 1.
- TMR_W, 27: lockout timer width; must hold LOCKOUT_CYCLES-1.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  factory reset; asynchronous, active-high.
- prog_p  in  1  single-cycle pulse: enter or leave programming.
- lock_p  in  1  single-cycle pulse: lock safe.
- confirm_p  in  1  single-cycle pulse: submit attempt.
- code  in  4*DIGIT_W  live switch code, digit 1 in the MSBs.
- open  out  1  safe open.
- wrong  out  1  lockout active.
- mode  out  1  programming mode.
- factory  out  1  stored password is all zeros.
- tries_left  out  2  remaining attempts before lockout.

## Operation
- Reset is asynchronous and active-high. Reset values:
  - state=OPEN, password=0, fail_cnt=0, timer=0.
  - open=1, wrong=0, mode=0, factory=1, tries_left=MAX_TRIES.
- FSM states: OPEN, PROG, LOCKED, LOCKOUT.
- OPEN:
  - lock_p -> LOCKED.
  - else prog_p -> PROG.
  - confirm_p is ignored.
  - If lock_p and prog_p arrive in the same cycle, lock_p wins.
- PROG:
  - prog_p -> password <= code (sampled that cycle), -> OPEN.
  - lock_p and confirm_p are ignored.
- LOCKED, on confirm_p:
  - code == password: go to OPEN, fail_cnt <= 0.
  - Mismatch with fail_cnt+1 < MAX_TRIES: fail_cnt++, stay LOCKED.
  - Mismatch with fail_cnt+1 == MAX_TRIES: go to LOCKOUT, fail_cnt <= 0, timer <= LOCKOUT_CYCLES-1.
  - prog_p and lock_p are ignored.
- LOCKOUT:
  - All pulses are ignored, including a correct confirm.
  - Each cycle: if timer==0, go to LOCKED; else timer--.
- Password compare is a full 4*DIGIT_W-bit equality. No partial match.
- fail_cnt persists across LOCKED cycles. It clears only on a successful unlock, on lockout entry, or on reset.

## Timing
- Outputs are registered decodes of next state and password:
  - open = (OPEN)
  - wrong = (LOCKOUT)
  - mode = (PROG)
  - factory = (password == 0)
  - tries_left = MAX_TRIES - fail_cnt
- Latency: each output changes on the clk edge that samples the triggering pulse, so it is visible 1 cycle after the pulse.
- wrong is high for exactly LOCKOUT_CYCLES consecutive cycles.
  - The first confirm_p accepted after lockout is the one sampled on the edge after wrong falls.
- factory updates on the same edge the password is written.
- rst asserted mid-lockout or mid-programming:
  - Immediately forces all reset values; timer and fail_cnt are cleared.
  - The first edge after rst deasserts behaves as in OPEN.
- A pulse held longer than 1 cycle is a protocol violation. Each high cycle counts as a separate event.

## Test plan
- Reset, then lock_p, then confirm_p with code=0 -> open 1->0->1; factory=1; tries_left stays 3.
- From OPEN, prog_p; set code=12'o5273; prog_p -> mode high for the interval, then 0; factory=0; password=0o5273.
- LOCKED with password 0o5273: confirm 0o1111 twice -> tries_left 3->2->1, open=0; confirm 0o5273 -> open=1, tries_left=3.
- With LOCKOUT_CYCLES=8: three wrong confirms -> wrong=1 for exactly 8 cycles, tries_left=3; a correct confirm during lockout -> no effect; a correct confirm after wrong falls -> open=1.
- OPEN with lock_p and prog_p in the same cycle -> LOCKED; mode stays 0.
- Assert rst in the 4th lockout cycle -> wrong=0, open=1, factory=1 asynchronously, before the next edge.

Source files
------------

// File: rtl/safe_access_ctrl.sv
// Access-control sequencer for the 4-digit safe: owns the stored password,
// the open/programming/locked/lockout state, the failed-attempt count and the lockout timer.
module safe_access_ctrl #(
   parameter int DIGIT_W        = 3,
   parameter int MAX_TRIES      = 3,
   parameter int LOCKOUT_CYCLES = 100_000_000,
   parameter int TMR_W          = 27
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 prog_p,
   input  logic                 lock_p,
   input  logic                 confirm_p,
   input  logic [4*DIGIT_W-1:0] code,
   output logic                 open,
   output logic                 wrong,
   output logic                 mode,
   output logic                 factory,
   output logic [1:0]           tries_left
);

   typedef enum logic [1:0] {S_OPEN, S_PROG, S_LOCKED, S_LOCKOUT} state_t;

   localparam logic [1:0]       MAX_T    = 2'(MAX_TRIES);
   localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(LOCKOUT_CYCLES - 1);

   state_t               state_q, state_d;
   logic [4*DIGIT_W-1:0] pwd_q, pwd_d;
   logic [1:0]           fail_q, fail_d;
   logic [TMR_W-1:0]     tmr_q, tmr_d;
   logic                 open_q, wrong_q, mode_q, factory_q;
   logic [1:0]           tries_q;

   always_comb begin
      state_d = state_q;
      pwd_d   = pwd_q;
      fail_d  = fail_q;
      tmr_d   = tmr_q;
      case (state_q)
         S_OPEN: begin
            // lock wins over prog when both arrive together
            if (lock_p)      state_d = S_LOCKED;
            else if (prog_p) state_d = S_PROG;
         end
         S_PROG: begin
            if (prog_p) begin
               pwd_d   = code;
               state_d = S_OPEN;
            end
         end
         S_LOCKED: begin
            if (confirm_p) begin
               if (code == pwd_q) begin
                  state_d = S_OPEN;
                  fail_d  = 2'd0;
               end else if (fail_q + 2'd1 == MAX_T) begin
                  state_d = S_LOCKOUT;
                  fail_d  = 2'd0;
                  tmr_d   = TMR_LOAD;
               end else begin
                  fail_d = fail_q + 2'd1;
               end
            end
         end
         S_LOCKOUT: begin
            // Loaded with LOCKOUT_CYCLES-1 so the exit lands exactly LOCKOUT_CYCLES edges later
            if (tmr_q == '0) state_d = S_LOCKED;
            else             tmr_d   = tmr_q - 1'b1;
         end
         default: state_d = S_OPEN;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_OPEN;
         pwd_q     <= '0;
         fail_q    <= 2'd0;
         tmr_q     <= '0;
         open_q    <= 1'b1;
         wrong_q   <= 1'b0;
         mode_q    <= 1'b0;
         factory_q <= 1'b1;
         tries_q   <= MAX_T;
      end else begin
         state_q   <= state_d;
         pwd_q     <= pwd_d;
         fail_q    <= fail_d;
         tmr_q     <= tmr_d;
         // Status LEDs decode the next state so they change on the triggering edge
         open_q    <= (state_d == S_OPEN);
         wrong_q   <= (state_d == S_LOCKOUT);
         mode_q    <= (state_d == S_PROG);
         factory_q <= (pwd_d == '0);
         tries_q   <= MAX_T - fail_d;
      end
   end

   assign open       = open_q;
   assign wrong      = wrong_q;
   assign mode       = mode_q;
   assign factory    = factory_q;
   assign tries_left = tries_q;

endmodule

// File: tb/tb_safe_access_ctrl.sv
// Directed bench for safe_access_ctrl: vector table for single-cycle behaviour,
// hand sequences for lockout duration and asynchronous reset.
module tb_safe_access_ctrl;

   localparam int DIGIT_W = 3;
   localparam int LOCK_N  = 8;

   logic        clk = 1'b0;
   logic        rst, prog_p, lock_p, confirm_p;
   logic [11:0] code;
   logic        open, wrong, mode, factory;
   logic [1:0]  tries_left;

   int n_chk  = 0;
   int n_fail = 0;

   safe_access_ctrl #(
      .DIGIT_W(DIGIT_W), .MAX_TRIES(3), .LOCKOUT_CYCLES(LOCK_N), .TMR_W(4)
   ) dut (
      .clk(clk), .rst(rst), .prog_p(prog_p), .lock_p(lock_p), .confirm_p(confirm_p),
      .code(code), .open(open), .wrong(wrong), .mode(mode), .factory(factory),
      .tries_left(tries_left)
   );

   always #5 clk = ~clk;

   // {open, wrong, mode, factory, tries_left}
   typedef struct {
      logic        prog;
      logic        lock;
      logic        conf;
      logic [11:0] code;
      logic [5:0]  exp;
   } vec_t;

   vec_t tbl[18];

   function automatic logic [5:0] outs();
      return {open, wrong, mode, factory, tries_left};
   endfunction

   task automatic chk(input string name, input logic [5:0] exp);
      n_chk++;
      if (outs() !== exp) begin
         n_fail++;
         $display("FAIL %s: got {open,wrong,mode,factory,tries}=%b expected %b", name, outs(), exp);
      end
   endtask

   // Drive at falling edge, let one rising edge sample, settle 1 time unit.
   task automatic step(input logic p, input logic l, input logic c, input logic [11:0] cd);
      @(negedge clk);
      prog_p = p; lock_p = l; confirm_p = c; code = cd;
      @(posedge clk);
      #1;
      prog_p = 1'b0; lock_p = 1'b0; confirm_p = 1'b0;
   endtask

   initial begin
      tbl[0]  = '{0, 1, 0, 12'o0000, 6'b000111}; // lock from open
      tbl[1]  = '{0, 0, 1, 12'o0000, 6'b100111}; // factory code unlocks
      tbl[2]  = '{1, 0, 0, 12'o0000, 6'b001111}; // enter programming
      tbl[3]  = '{0, 0, 0, 12'o5273, 6'b001111}; // switches change, no write yet
      tbl[4]  = '{1, 0, 0, 12'o5273, 6'b100011}; // write password, factory drops
      tbl[5]  = '{0, 1, 0, 12'o5273, 6'b000011};
      tbl[6]  = '{0, 0, 1, 12'o1111, 6'b000010};
      tbl[7]  = '{0, 0, 1, 12'o1111, 6'b000001};
      tbl[8]  = '{0, 0, 1, 12'o5273, 6'b100011}; // correct code clears fail count
      tbl[9]  = '{1, 1, 0, 12'o5273, 6'b000011}; // lock beats prog
      tbl[10] = '{0, 0, 1, 12'o1111, 6'b000010};
      tbl[11] = '{1, 0, 0, 12'o5273, 6'b000010}; // prog ignored while locked
      tbl[12] = '{0, 0, 1, 12'o5273, 6'b100011};
      tbl[13] = '{1, 0, 0, 12'o5273, 6'b001011};
      tbl[14] = '{0, 1, 1, 12'o1234, 6'b001011}; // lock/confirm ignored in prog
      tbl[15] = '{1, 0, 0, 12'o0000, 6'b100111}; // writing zeros restores factory
      tbl[16] = '{1, 0, 0, 12'o0000, 6'b001111};
      tbl[17] = '{1, 0, 0, 12'o5273, 6'b100011};

      rst = 1'b1; prog_p = 1'b0; lock_p = 1'b0; confirm_p = 1'b0; code = '0;
      #2;
      chk("reset_values", 6'b100111);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 18; i++) begin
         step(tbl[i].prog, tbl[i].lock, tbl[i].conf, tbl[i].code);
         chk($sformatf("vec%0d", i), tbl[i].exp);
      end

      // Lockout duration and blocking of a correct code
      step(0, 1, 0, 12'o5273);  chk("lo_lock", 6'b000011);
      step(0, 0, 1, 12'o1111);  chk("lo_bad1", 6'b000010);
      step(0, 0, 1, 12'o1111);  chk("lo_bad2", 6'b000001);
      step(0, 0, 1, 12'o1111);  chk("lo_cyc1", 6'b010011);
      for (int c = 2; c <= LOCK_N; c++) begin
         step(0, 0, (c == 4), 12'o5273);
         chk($sformatf("lo_cyc%0d", c), 6'b010011);
      end
      step(0, 0, 0, 12'o5273);  chk("lo_exit", 6'b000011);
      step(0, 0, 1, 12'o5273);  chk("lo_unlock", 6'b100011);

      // Asynchronous reset in the 4th lockout cycle
      step(0, 1, 0, 12'o5273);
      step(0, 0, 1, 12'o1111);
      step(0, 0, 1, 12'o1111);
      step(0, 0, 1, 12'o1111);  chk("rs_cyc1", 6'b010011);
      step(0, 0, 0, 12'o5273);
      step(0, 0, 0, 12'o5273);
      step(0, 0, 0, 12'o5273);  chk("rs_cyc4", 6'b010011);
      #2 rst = 1'b1;
      #1 chk("rs_async", 6'b100111);
      @(negedge clk);
      rst = 1'b0;
      step(0, 1, 0, 12'o0000);  chk("rs_then_lock", 6'b000111);
      step(0, 0, 1, 12'o0000);  chk("rs_pwd_cleared", 6'b100111);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
